// File: rtl/control_seq.sv
// control_seq: microcode sequencer for the EDiC CPU core.
// Steps a micro-step counter, latches the fetched instruction, and forms the
// control-store address {flags, instruction, step}. Microprograms end on the
// EOM bit of the control word, a wait input stalls the sequencer, the all-ones
// opcode parks the core in HALT until resume, and running off the end of the
// step counter without EOM raises a one-cycle overflow pulse.

module control_seq #(
    parameter int INSTR_W = 8,
    parameter int STEP_W  = 3,
    parameter int FLAG_W  = 2,
    parameter int CTRL_W  = 16,
    parameter int IMM_LSB = 2,
    parameter int IMM_FW  = 3
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [FLAG_W-1:0]                 i_flags,
    input  logic [INSTR_W-1:0]                i_instruction,
    input  logic                              i_wait,
    input  logic                              i_resume,
    output logic [FLAG_W+INSTR_W+STEP_W-1:0]  o_romAddr,
    input  logic [CTRL_W-1:0]                 i_romData,
    output logic [CTRL_W-3:0]                 o_ctrl,
    output logic [INSTR_W-1:0]                o_immediate,
    output logic                              o_ramReadDataSelect,
    output logic                              o_pcNOe,
    output logic                              o_hlt,
    output logic                              o_stepOverflow,
    output logic [STEP_W-1:0]                 o_step
);

    // Sequencer states; one bit kept as a plain constant pair.
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // Named micro-steps. Steps 0 and 1 form the fixed fetch; execution
    // starts at step 2 and may run up to the all-ones step.
    localparam logic [STEP_W-1:0] STEP_FETCH = '0;
    localparam logic [STEP_W-1:0] STEP_LATCH = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_EXEC  = STEP_W'(2);
    localparam logic [STEP_W-1:0] STEP_LAST  = '1;
    localparam logic [STEP_W-1:0] STEP_INC   = STEP_W'(1);

    // Architectural state.
    logic [0:0]         r_state;
    logic [STEP_W-1:0]  r_step;
    logic [INSTR_W-1:0] r_instruction;
    logic               r_stepOverflow;

    // Next-state values and decoded control-word fields.
    logic [0:0]         w_stateNext;
    logic [STEP_W-1:0]  w_stepNext;
    logic [INSTR_W-1:0] w_instrNext;
    logic               w_overflowNext;
    logic               w_eom;
    logic               w_nImmOut;
    logic               w_isHaltOpcode;
    logic               w_inHalt;
    logic [IMM_FW-1:0]  w_immField;

    // The two sequencing bits live in the low end of the control word and
    // are consumed here; the rest of the word goes out to the datapath.
    assign w_eom          = i_romData[1];
    assign w_nImmOut      = i_romData[0];
    assign w_isHaltOpcode = &r_instruction;
    assign w_inHalt       = (r_state == ST_HALT);
    assign w_immField     = r_instruction[IMM_LSB+IMM_FW-1:IMM_LSB];

    // Next-state decision. HALT only listens to resume. In RUN a wait holds
    // everything; otherwise the fetch steps always run, step 2 of the
    // all-ones opcode enters HALT with the step frozen, EOM ends the
    // microprogram, and the last step without EOM wraps and flags overflow.
    always_comb begin
        w_stateNext    = r_state;
        w_stepNext     = r_step;
        w_instrNext    = r_instruction;
        w_overflowNext = 1'b0;
        if (w_inHalt) begin
            if (i_resume) begin
                w_stateNext = ST_RUN;
                w_stepNext  = STEP_FETCH;
                w_instrNext = '0;
            end
        end else if (!i_wait) begin
            if (r_step == STEP_FETCH) begin
                w_stepNext = STEP_LATCH;
            end else if (r_step == STEP_LATCH) begin
                w_stepNext  = STEP_EXEC;
                w_instrNext = i_instruction;
            end else if (r_step == STEP_EXEC && w_isHaltOpcode) begin
                w_stateNext = ST_HALT;
            end else if (w_eom) begin
                w_stepNext = STEP_FETCH;
            end else if (r_step == STEP_LAST) begin
                w_stepNext     = STEP_FETCH;
                w_overflowNext = 1'b1;
            end else begin
                w_stepNext = r_step + STEP_INC;
            end
        end
    end

    // State registers with synchronous reset that overrides wait and resume.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_RUN;
            r_step         <= STEP_FETCH;
            r_instruction  <= '0;
            r_stepOverflow <= 1'b0;
        end else begin
            r_state        <= w_stateNext;
            r_step         <= w_stepNext;
            r_instruction  <= w_instrNext;
            r_stepOverflow <= w_overflowNext;
        end
    end

    // Flags feed the ROM address combinationally so conditional microcode
    // sees them in the same cycle.
    assign o_romAddr = {i_flags, r_instruction, r_step};

    // In HALT every datapath control line is quiet, including the immediate.
    assign o_ctrl      = w_inHalt ? '0 : i_romData[CTRL_W-1:2];
    assign o_immediate = (!w_inHalt && !w_nImmOut) ? INSTR_W'(w_immField) : '0;

    // Fetch-phase bus steering derived directly from the step counter.
    assign o_pcNOe             = (r_step != STEP_FETCH);
    assign o_ramReadDataSelect = (r_step == STEP_LATCH);

    assign o_hlt          = w_inHalt;
    assign o_stepOverflow = r_stepOverflow;
    assign o_step         = r_step;

endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: randomized scoreboard bench for control_seq. A stimulus
// process drives one cycle at a time and pushes the expected outputs, taken
// from a step-list model of each microprogram; a monitor pops and compares
// on every falling edge.

module tb_control_seq;

    typedef struct packed {
        logic [12:0] romAddr;
        logic [13:0] ctrl;
        logic [7:0]  imm;
        logic [2:0]  step;
        logic        hlt;
        logic        ovf;
        logic        pcNOe;
        logic        rds;
    } obs_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  flags = '0;
    logic [7:0]  instrBus = '0;
    logic        waitIn = 1'b0;
    logic        resume = 1'b0;
    logic [12:0] romAddr;
    logic [15:0] romData;
    logic [13:0] ctrl;
    logic [7:0]  immediate;
    logic        ramReadDataSelect;
    logic        pcNOe;
    logic        hlt;
    logic        stepOverflow;
    logic [2:0]  step;

    int romEomStep = 3;
    int romImmStep = 7;

    int   checks = 0;
    int   errors = 0;
    obs_t expQ[$];

    int         stepQ[$];
    logic [7:0] latched = '0;
    bit         halted = 1'b0;
    bit         pendOvf = 1'b0;
    bit         modelValid = 1'b0;

    control_seq dut (
        .i_clk              (clock),
        .i_reset            (reset),
        .i_flags            (flags),
        .i_instruction      (instrBus),
        .i_wait             (waitIn),
        .i_resume           (resume),
        .o_romAddr          (romAddr),
        .i_romData          (romData),
        .o_ctrl             (ctrl),
        .o_immediate        (immediate),
        .o_ramReadDataSelect(ramReadDataSelect),
        .o_pcNOe            (pcNOe),
        .o_hlt              (hlt),
        .o_stepOverflow     (stepOverflow),
        .o_step             (step)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Control-store contents: a hashed payload per address, EOM at the
    // configured step (plus noise at steps 0/1, which must be ignored), and
    // nImmOut low only at the configured step.
    function automatic logic [15:0] romWord(input logic [12:0] addr, input int eomStep,
                                            input int immStep);
        logic [31:0] h;
        int          s;
        h = {19'd0, addr} * 32'h9E3779B1;
        h = h ^ (h >> 15);
        s = int'(addr[2:0]);
        romWord[15:2] = h[13:0];
        romWord[1]    = (s == eomStep) || (s < 2 && h[20]);
        romWord[0]    = (s != immStep);
    endfunction

    assign romData = romWord(romAddr, romEomStep, romImmStep);

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input obs_t e);
        checkField("romAddr", 32'(romAddr), 32'(e.romAddr));
        checkField("ctrl", 32'(ctrl), 32'(e.ctrl));
        checkField("immediate", 32'(immediate), 32'(e.imm));
        checkField("step", 32'(step), 32'(e.step));
        checkField("hlt", 32'(hlt), 32'(e.hlt));
        checkField("stepOverflow", 32'(stepOverflow), 32'(e.ovf));
        checkField("pcNOe", 32'(pcNOe), 32'(e.pcNOe));
        checkField("ramReadDataSelect", 32'(ramReadDataSelect), 32'(e.rds));
    endtask

    // Monitor: compare whatever the stimulus side predicted for this cycle.
    always @(negedge clock) begin
        if (expQ.size() != 0) checkOutput(expQ.pop_front());
    end

    // Drive one cycle, predict its outputs, then advance the model past the edge.
    task automatic applyStimulus(input logic w, input logic res, input logic rst,
                                 input logic [7:0] bus);
        obs_t        e;
        int          s;
        int          lastStep;
        logic [15:0] word;
        waitIn   = w;
        resume   = res;
        reset    = rst;
        instrBus = bus;
        flags    = 2'($urandom_range(3));
        if (modelValid) begin
            if (halted) begin
                e.step    = 3'd2;
                e.romAddr = {flags, latched, 3'd2};
                e.ctrl    = '0;
                e.imm     = '0;
                e.hlt     = 1'b1;
                e.pcNOe   = 1'b1;
                e.rds     = 1'b0;
            end else begin
                s         = stepQ[0];
                e.step    = 3'(s);
                e.romAddr = {flags, latched, 3'(s)};
                word      = romWord(e.romAddr, romEomStep, romImmStep);
                e.ctrl    = word[15:2];
                e.imm     = word[0] ? 8'd0 : {5'd0, latched[4:2]};
                e.hlt     = 1'b0;
                e.pcNOe   = (s != 0);
                e.rds     = (s == 1);
            end
            e.ovf = pendOvf;
            expQ.push_back(e);
        end
        @(posedge clock);
        #1;
        if (rst) begin
            halted     = 1'b0;
            latched    = '0;
            pendOvf    = 1'b0;
            stepQ      = '{0, 1};
            modelValid = 1'b1;
        end else if (!modelValid) begin
            pendOvf = 1'b0;
        end else if (halted) begin
            pendOvf = 1'b0;
            if (res) begin
                halted  = 1'b0;
                latched = '0;
                stepQ   = '{0, 1};
            end
        end else if (w) begin
            pendOvf = 1'b0;
        end else begin
            s       = stepQ.pop_front();
            pendOvf = 1'b0;
            if (s == 1) begin
                latched = bus;
                if (bus == 8'hFF) begin
                    stepQ.push_back(2);
                end else begin
                    lastStep = (romEomStep >= 2) ? romEomStep : 7;
                    for (int k = 2; k <= lastStep; k++) stepQ.push_back(k);
                end
            end else if (s == 2 && latched == 8'hFF) begin
                halted = 1'b1;
            end else if (stepQ.size() == 0) begin
                pendOvf = (s == 7 && romEomStep != 7);
                stepQ   = '{0, 1};
            end
        end
    endtask

    // Run n plain cycles with no wait, resume or reset.
    task automatic runCycles(input int n, input logic [7:0] bus);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, bus);
    endtask

    initial begin
        logic       w;
        logic       res;
        logic       rst;
        logic [7:0] bus;

        @(posedge clock);
        #1;
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);

        // Opcode 0x05, EOM at step 3: steps 0,1,2,3 then next fetch.
        romEomStep = 3;
        romImmStep = 7;
        runCycles(4, 8'h05);

        // Wait during step 1 while the bus changes; 0x33 must be latched.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h11);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h11);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h22);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h33);
        runCycles(2, 8'h33);

        // No EOM: steps 0..7, wrap with overflow pulse on the next cycle.
        romEomStep = -1;
        runCycles(8, 8'h05);

        // Halt opcode, then 10 halted cycles with wait toggling, then resume.
        romEomStep = 2;
        runCycles(3, 8'hFF);
        for (int i = 0; i < 10; i++) applyStimulus(1'(i % 2), 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);

        // Immediate field: 0b000_101_00 gives 5 only where nImmOut is low.
        romEomStep = 3;
        romImmStep = 2;
        runCycles(4, 8'h14);
        romImmStep = 3;
        runCycles(4, 8'h14);

        // Reset at step 4 together with wait and resume.
        romEomStep = -1;
        romImmStep = 7;
        runCycles(4, 8'h05);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h05);
        runCycles(3, 8'h05);

        // Randomized traffic with config changes at fetch boundaries.
        for (int i = 0; i < 600; i++) begin
            if (!halted && stepQ.size() == 2 && stepQ[0] == 0 && $urandom_range(1) == 1) begin
                romEomStep = int'($urandom_range(8)) - 1;
                romImmStep = int'($urandom_range(7));
            end
            w   = ($urandom_range(3) == 0);
            res = halted ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
            rst = ($urandom_range(149) == 0);
            bus = ($urandom_range(11) == 0) ? 8'hFF : 8'($urandom_range(254));
            applyStimulus(w, res, rst, bus);
        end

        @(negedge clock);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: actual=%0d pending required=0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
